// File: rtl/fb_mem_arbiter.sv
// Frame-buffer memory arbiter: shares one burst command port between a camera
// write stream and a display read stream, with read priority and starvation relief.
module fb_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 21,
    parameter int unsigned BURST_LEN   = 32,
    parameter int unsigned FRAME_WORDS = 307200,
    parameter int unsigned FB_BASE     = 0,
    parameter int unsigned WR_MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_frame_start,
    input  logic [7:0]            wr_fifo_level,
    input  logic                  rd_frame_start,
    input  logic [7:0]            rd_fifo_space,
    output logic                  mem_cmd_valid,
    input  logic                  mem_cmd_ready,
    output logic                  mem_cmd_write,
    output logic [ADDR_WIDTH-1:0] mem_cmd_addr,
    input  logic                  mem_beat,
    output logic                  grant_wr,
    output logic                  grant_rd,
    output logic                  wr_frame_full
);

    localparam int unsigned BW = $clog2(BURST_LEN) + 1;
    localparam int unsigned SW = (WR_MAX_WAIT < 1) ? 1 : $clog2(WR_MAX_WAIT + 1);

    localparam logic [8:0]            BL_LVL     = 9'(BURST_LEN);
    localparam logic [ADDR_WIDTH:0]   BL_EXT     = (ADDR_WIDTH + 1)'(BURST_LEN);
    localparam logic [ADDR_WIDTH:0]   FW_EXT     = (ADDR_WIDTH + 1)'(FRAME_WORDS);
    localparam logic [ADDR_WIDTH-1:0] FW_ADR     = ADDR_WIDTH'(FRAME_WORDS);
    localparam logic [ADDR_WIDTH-1:0] BASE_ADR   = ADDR_WIDTH'(FB_BASE);
    localparam logic [BW-1:0]         LAST_BEAT  = BW'(BURST_LEN - 1);
    localparam logic [SW-1:0]         STARVE_MAX = SW'(WR_MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        BURST
    } state_e;

    state_e                  state_q;
    logic                    cmd_valid_q;
    logic                    cmd_write_q;
    logic [ADDR_WIDTH-1:0]   cmd_addr_q;
    logic                    grant_wr_q;
    logic                    grant_rd_q;
    logic                    wr_full_q;
    logic [ADDR_WIDTH-1:0]   wr_off_q;
    logic [ADDR_WIDTH-1:0]   rd_off_q;
    logic [SW-1:0]           starve_q;
    logic [BW-1:0]           beat_q;
    logic                    wr_pend_q;
    logic                    rd_pend_q;

    logic                    in_idle;
    logic                    wr_restart;
    logic                    rd_restart;
    logic [ADDR_WIDTH-1:0]   wr_off_now;
    logic [ADDR_WIDTH-1:0]   rd_off_now;
    logic                    rd_elig;
    logic                    wr_elig;
    logic                    pick_wr;
    logic                    wr_pend_now;
    logic                    rd_pend_now;
    logic                    burst_done;
    logic [ADDR_WIDTH:0]     wr_next;
    logic [ADDR_WIDTH:0]     rd_next;

    // A frame start seen in IDLE takes effect before the same-edge decision,
    // so both the offset and the full flag are forwarded combinationally.
    always_comb begin
        in_idle     = (state_q == IDLE);
        wr_restart  = in_idle && wr_frame_start;
        rd_restart  = in_idle && rd_frame_start;
        wr_off_now  = wr_restart ? '0 : wr_off_q;
        rd_off_now  = rd_restart ? '0 : rd_off_q;
        rd_elig     = ({1'b0, rd_fifo_space} >= BL_LVL);
        wr_elig     = ({1'b0, wr_fifo_level} >= BL_LVL) && !(wr_full_q && !wr_restart);
        pick_wr     = wr_elig && (!rd_elig || (starve_q >= STARVE_MAX));
        wr_pend_now = wr_pend_q || wr_frame_start;
        rd_pend_now = rd_pend_q || rd_frame_start;
        burst_done  = (state_q == BURST) && mem_beat && (beat_q == LAST_BEAT);
        wr_next     = {1'b0, wr_off_q} + BL_EXT;
        rd_next     = {1'b0, rd_off_q} + BL_EXT;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cmd_valid_q <= 1'b0;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= '0;
            grant_wr_q  <= 1'b0;
            grant_rd_q  <= 1'b0;
            wr_full_q   <= 1'b0;
            wr_off_q    <= '0;
            rd_off_q    <= '0;
            starve_q    <= '0;
            beat_q      <= '0;
            wr_pend_q   <= 1'b0;
            rd_pend_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    wr_off_q <= wr_off_now;
                    rd_off_q <= rd_off_now;
                    if (wr_restart) begin
                        wr_full_q <= 1'b0;
                    end
                    if (rd_elig || wr_elig) begin
                        state_q     <= CMD;
                        cmd_valid_q <= 1'b1;
                        cmd_write_q <= pick_wr;
                        cmd_addr_q  <= BASE_ADR + (pick_wr ? wr_off_now : rd_off_now);
                        if (pick_wr) begin
                            starve_q <= '0;
                        end else if (wr_elig && (starve_q < STARVE_MAX)) begin
                            starve_q <= starve_q + SW'(1);
                        end
                    end
                end

                CMD: begin
                    wr_pend_q <= wr_pend_now;
                    rd_pend_q <= rd_pend_now;
                    if (mem_cmd_ready) begin
                        state_q     <= BURST;
                        cmd_valid_q <= 1'b0;
                        grant_wr_q  <= cmd_write_q;
                        grant_rd_q  <= !cmd_write_q;
                        beat_q      <= '0;
                    end
                end

                BURST: begin
                    if (burst_done) begin
                        state_q    <= IDLE;
                        grant_wr_q <= 1'b0;
                        grant_rd_q <= 1'b0;
                        beat_q     <= '0;
                        wr_pend_q  <= 1'b0;
                        rd_pend_q  <= 1'b0;
                        // A pending frame restart overrides this burst's advance.
                        if (wr_pend_now) begin
                            wr_off_q  <= '0;
                            wr_full_q <= 1'b0;
                        end else if (grant_wr_q) begin
                            if (wr_next >= FW_EXT) begin
                                wr_off_q  <= FW_ADR;
                                wr_full_q <= 1'b1;
                            end else begin
                                wr_off_q <= wr_next[ADDR_WIDTH-1:0];
                            end
                        end
                        if (rd_pend_now) begin
                            rd_off_q <= '0;
                        end else if (grant_rd_q) begin
                            rd_off_q <= (rd_next >= FW_EXT) ? '0 : rd_next[ADDR_WIDTH-1:0];
                        end
                    end else begin
                        wr_pend_q <= wr_pend_now;
                        rd_pend_q <= rd_pend_now;
                        if (mem_beat) begin
                            beat_q <= beat_q + BW'(1);
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_cmd_valid = cmd_valid_q;
    assign mem_cmd_write = cmd_write_q;
    assign mem_cmd_addr  = cmd_addr_q;
    assign grant_wr      = grant_wr_q;
    assign grant_rd      = grant_rd_q;
    assign wr_frame_full = wr_full_q;

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Bench for fb_mem_arbiter: two instances (small and full-size frame) share
// stimulus and are checked every cycle against a transaction-level model.
module tb_fb_mem_arbiter;

    localparam int AW   = 21;
    localparam int BL   = 32;
    localparam int MAXW = 4;
    localparam int FW_A = 64;
    localparam int FW_B = 307200;
    localparam int BASE = 0;

    logic           clk = 1'b0;
    logic           reset_n = 1'b1;
    logic           wr_frame_start = 1'b0;
    logic [7:0]     wr_fifo_level = '0;
    logic           rd_frame_start = 1'b0;
    logic [7:0]     rd_fifo_space = '0;
    logic           mem_cmd_ready = 1'b0;
    logic           mem_beat = 1'b0;

    logic [1:0]     v, w, gw, gr, fl;
    logic [AW-1:0]  a0, a1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fb_mem_arbiter #(.ADDR_WIDTH(AW), .BURST_LEN(BL), .FRAME_WORDS(FW_A),
                     .FB_BASE(BASE), .WR_MAX_WAIT(MAXW)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .wr_frame_start(wr_frame_start), .wr_fifo_level(wr_fifo_level),
        .rd_frame_start(rd_frame_start), .rd_fifo_space(rd_fifo_space),
        .mem_cmd_valid(v[0]), .mem_cmd_ready(mem_cmd_ready),
        .mem_cmd_write(w[0]), .mem_cmd_addr(a0), .mem_beat(mem_beat),
        .grant_wr(gw[0]), .grant_rd(gr[0]), .wr_frame_full(fl[0])
    );

    fb_mem_arbiter #(.ADDR_WIDTH(AW), .BURST_LEN(BL), .FRAME_WORDS(FW_B),
                     .FB_BASE(BASE), .WR_MAX_WAIT(MAXW)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .wr_frame_start(wr_frame_start), .wr_fifo_level(wr_fifo_level),
        .rd_frame_start(rd_frame_start), .rd_fifo_space(rd_fifo_space),
        .mem_cmd_valid(v[1]), .mem_cmd_ready(mem_cmd_ready),
        .mem_cmd_write(w[1]), .mem_cmd_addr(a1), .mem_beat(mem_beat),
        .grant_wr(gw[1]), .grant_rd(gr[1]), .wr_frame_full(fl[1])
    );

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // ---------------- transaction-level model ----------------
    // phase: 0 waiting for a decision, 1 command offered, 2 data burst
    int m_ph[2], m_beats[2], m_woff[2], m_roff[2], m_starve[2];
    int m_full[2], m_wp[2], m_rp[2];
    int e_v[2], e_w[2], e_a[2], e_gw[2], e_gr[2];

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ph[k] = 0; m_beats[k] = 0; m_woff[k] = 0; m_roff[k] = 0;
            m_starve[k] = 0; m_full[k] = 0; m_wp[k] = 0; m_rp[k] = 0;
            e_v[k] = 0; e_w[k] = 0; e_a[k] = 0; e_gw[k] = 0; e_gr[k] = 0;
        end
    endfunction

    function automatic void model_step(input int k);
        int fw, re, we, pw;
        fw = (k == 0) ? FW_A : FW_B;
        if (m_ph[k] == 0) begin
            if (wr_frame_start) begin m_woff[k] = 0; m_full[k] = 0; end
            if (rd_frame_start) m_roff[k] = 0;
            re = (int'(rd_fifo_space) >= BL) ? 1 : 0;
            we = (int'(wr_fifo_level) >= BL && m_full[k] == 0) ? 1 : 0;
            if (re != 0 || we != 0) begin
                pw = (we != 0 && (re == 0 || m_starve[k] >= MAXW)) ? 1 : 0;
                if (pw != 0) m_starve[k] = 0;
                else if (we != 0 && m_starve[k] < MAXW) m_starve[k]++;
                e_v[k] = 1;
                e_w[k] = pw;
                e_a[k] = (BASE + ((pw != 0) ? m_woff[k] : m_roff[k])) % (1 << AW);
                m_ph[k] = 1;
            end
        end else if (m_ph[k] == 1) begin
            if (wr_frame_start) m_wp[k] = 1;
            if (rd_frame_start) m_rp[k] = 1;
            if (mem_cmd_ready) begin
                m_ph[k] = 2; e_v[k] = 0; m_beats[k] = 0;
                e_gw[k] = e_w[k]; e_gr[k] = 1 - e_w[k];
            end
        end else begin
            if (wr_frame_start) m_wp[k] = 1;
            if (rd_frame_start) m_rp[k] = 1;
            if (mem_beat) begin
                m_beats[k]++;
                if (m_beats[k] == BL) begin
                    if (e_gw[k] != 0) begin
                        m_woff[k] += BL;
                        if (m_woff[k] >= fw) begin m_woff[k] = fw; m_full[k] = 1; end
                    end else begin
                        m_roff[k] = (m_roff[k] + BL) % fw;
                    end
                    if (m_wp[k] != 0) begin m_woff[k] = 0; m_full[k] = 0; end
                    if (m_rp[k] != 0) m_roff[k] = 0;
                    m_wp[k] = 0; m_rp[k] = 0;
                    e_gw[k] = 0; e_gr[k] = 0; m_ph[k] = 0;
                end
            end
        end
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else for (int k = 0; k < 2; k++) model_step(k);
    end

    // ---------------- per-cycle compare and command log ----------------
    int la0[$], la1[$], lw0[$], lw1[$];

    function automatic int get_a(input int k);
        return (k == 0) ? int'(a0) : int'(a1);
    endfunction
    function automatic int log_size(input int k);
        return (k == 0) ? la0.size() : la1.size();
    endfunction

    always @(negedge clk) begin
        if (reset_n) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("valid[%0d]", k), int'(v[k]), e_v[k]);
                check($sformatf("write[%0d]", k), int'(w[k]), e_w[k]);
                check($sformatf("addr[%0d]", k), get_a(k), e_a[k]);
                check($sformatf("grant_wr[%0d]", k), int'(gw[k]), e_gw[k]);
                check($sformatf("grant_rd[%0d]", k), int'(gr[k]), e_gr[k]);
                check($sformatf("frame_full[%0d]", k), int'(fl[k]), m_full[k]);
                check($sformatf("grant_excl[%0d]", k), int'(gw[k] & gr[k]), 0);
                if (v[k] && mem_cmd_ready) begin
                    if (k == 0) begin la0.push_back(int'(a0)); lw0.push_back(int'(w[0])); end
                    else        begin la1.push_back(int'(a1)); lw1.push_back(int'(w[1])); end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic check_zero(input string nm);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s valid[%0d]", nm, k), int'(v[k]), 0);
            check($sformatf("%s write[%0d]", nm, k), int'(w[k]), 0);
            check($sformatf("%s addr[%0d]", nm, k), get_a(k), 0);
            check($sformatf("%s gwr[%0d]", nm, k), int'(gw[k]), 0);
            check($sformatf("%s grd[%0d]", nm, k), int'(gr[k]), 0);
            check($sformatf("%s full[%0d]", nm, k), int'(fl[k]), 0);
        end
    endtask

    task automatic do_reset(input int rd, input int wr);
        reset_n = 1'b0;
        wr_frame_start = 1'b0; rd_frame_start = 1'b0;
        rd_fifo_space = 8'(rd); wr_fifo_level = 8'(wr);
        mem_cmd_ready = 1'b1; mem_beat = 1'b1;
        #1;
        check_zero("reset");
        step(2);
        la0.delete(); la1.delete(); lw0.delete(); lw1.delete();
        reset_n = 1'b1;
    endtask

    task automatic wait_log(input int k, input int n, input int maxc, input string nm);
        int c = 0;
        while (log_size(k) < n && c < maxc) begin step(1); c++; end
        check({nm, " cmd count reached"}, (log_size(k) >= n) ? 1 : 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit hit, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ea[6] = '{0, 32, 64, 96, 0, 128};
        int ew[6] = '{0, 0, 0, 0, 1, 0};
        int c;
        #3;

        // Read priority then starvation relief (full-size frame instance)
        do_reset(64, 64);
        wait_log(1, 6, 500, "prio");
        for (int i = 0; i < 6; i++) begin
            if (i < la1.size()) begin
                check($sformatf("prio addr #%0d", i), la1[i], ea[i]);
                check($sformatf("prio write #%0d", i), lw1[i], ew[i]);
            end
        end

        // Command held stable while the controller is not ready
        do_reset(64, 0);
        wait_log(1, 1, 50, "hold first");
        mem_cmd_ready = 1'b0;
        c = 0;
        while (!v[1] && c < 100) begin @(negedge clk); c++; end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold valid", int'(v[1]), 1);
            check("hold addr", int'(a1), 32);
            check("hold write", int'(w[1]), 0);
            check("hold no grant", int'(gr[1]), 0);
        end
        @(posedge clk); #2;
        mem_cmd_ready = 1'b1;
        @(negedge clk);
        check("grant before handshake edge", int'(gr[1]), 0);
        @(negedge clk);
        check("grant after handshake", int'(gr[1]), 1);
        check("valid cleared", int'(v[1]), 0);

        // Read wrap and write-full on the 64-word frame instance
        do_reset(64, 0);
        wait_log(0, 3, 200, "wrap");
        rd_fifo_space = 8'd0;
        if (la0.size() >= 3) begin
            check("wrap addr #0", la0[0], 0);
            check("wrap addr #1", la0[1], 32);
            check("wrap addr #2", la0[2], 0);
        end
        wr_fifo_level = 8'd64;
        c = 0;
        while (!fl[0] && c < 300) begin step(1); c++; end
        check("full set", int'(fl[0]), 1);
        check("full cmd count", la0.size(), 5);
        if (la0.size() >= 5) begin
            check("write addr #0", la0[3], 0);
            check("write flag #0", lw0[3], 1);
            check("write addr #1", la0[4], 32);
            check("write flag #1", lw0[4], 1);
        end
        step(80);
        check("no write while full", la0.size(), 5);
        wr_frame_start = 1'b1;
        step(1);
        wr_frame_start = 1'b0;
        check("full cleared by frame start", int'(fl[0]), 0);
        wait_log(0, 6, 20, "restart write");
        if (la0.size() >= 6) begin
            check("restart write addr", la0[5], 0);
            check("restart write flag", lw0[5], 1);
        end

        // Display frame start in the middle of the read at 96
        do_reset(64, 0);
        wait_log(1, 4, 300, "midburst");
        step(9);
        rd_frame_start = 1'b1;
        step(1);
        rd_frame_start = 1'b0;
        wait_log(1, 5, 200, "midburst next");
        if (la1.size() >= 5) begin
            check("midburst read addr", la1[3], 96);
            check("read after frame start", la1[4], 0);
        end

        // Reset during a write burst
        do_reset(0, 64);
        c = 0;
        while (!gw[0] && c < 50) begin step(1); c++; end
        check("write burst started", int'(gw[0]), 1);
        step(4);
        reset_n = 1'b0;
        #1;
        check_zero("midburst reset");
        step(2);
        la0.delete(); la1.delete(); lw0.delete(); lw1.delete();
        reset_n = 1'b1;
        wait_log(0, 1, 50, "post reset");
        if (la0.size() >= 1) begin
            check("post reset addr", la0[0], BASE);
            check("post reset write", lw0[0], 1);
        end

        // Randomized traffic, checked cycle by cycle against the model
        do_reset(0, 0);
        for (int i = 0; i < 3000; i++) begin
            rd_fifo_space  = 8'($urandom_range(0, 64));
            wr_fifo_level  = 8'($urandom_range(0, 64));
            mem_cmd_ready  = ($urandom_range(0, 3) != 0);
            mem_beat       = ($urandom_range(0, 4) != 0);
            wr_frame_start = ($urandom_range(0, 49) == 0);
            rd_frame_start = ($urandom_range(0, 49) == 0);
            step(1);
        end
        wr_frame_start = 1'b0; rd_frame_start = 1'b0;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
